// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared data bus with a
// dead turnaround cycle between owners. Optional forced release: BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int N_SRC    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         req,
    input  logic [N_SRC-1:0]         last,
    output logic [N_SRC-1:0]         grant,
    output logic [N_SRC-1:0]         bus_en,
    output logic [$clog2(N_SRC)-1:0] owner,
    output logic                     bus_busy,
    output logic                     timeout
);

    localparam int W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWN   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   win;
    logic [W-1:0]   win_n;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_n;
    logic [W-1:0]   base;
    logic [W-1:0]   cand;
    logic           found;
    logic           hold_hit;
    logic           release_own;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    assign hold_hit = (state == OWN) && (cnt == CW'(MAX_HOLD - 1));
    assign timeout  = hold_hit;

    // Count consecutive OWN cycles; any other transition restarts from zero.
    always_comb begin
        cnt_n = '0;
        if (state == OWN && state_n == OWN)
            cnt_n = cnt + CW'(1);
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_n;
    end
`else
    logic unused_hold;

    assign unused_hold = (MAX_HOLD == 0);
    assign hold_hit    = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Search starts after the last owner; in OWN the releasing owner is the
    // new pointer, so a lone requester still finds itself last in the ring.
    assign base = (state == OWN) ? win : ptr;

    // Round-robin search over req, wrapping from base+1.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = (int'(base) + i) % N_SRC;
            if (req[idx]) begin
                found = 1'b1;
                cand  = idx[W-1:0];
            end
        end
    end

    assign release_own = !req[win] || last[win] || hold_hit;

    // Next-state, winner and pointer update.
    always_comb begin
        state_n = state;
        win_n   = win;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    win_n   = cand;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[win]) begin
                    state_n = OWN;
                end else begin
                    ptr_n   = win;
                    state_n = IDLE;
                end
            end
            OWN: begin
                if (release_own) begin
                    ptr_n = win;
                    if (found) begin
                        win_n   = cand;
                        state_n = GRANT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, winner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            win   <= '0;
            ptr   <= W'(N_SRC - 1);
        end else begin
            state <= state_n;
            win   <= win_n;
            ptr   <= ptr_n;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        logic [N_SRC-1:0] dec;
        dec      = {{(N_SRC-1){1'b0}}, 1'b1} << win;
        grant    = '0;
        bus_en   = '0;
        owner    = '0;
        if (state != IDLE) begin
            grant = dec;
            owner = win;
        end
        if (state == OWN)
            bus_en = dec;
        bus_busy = |grant;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, directed corner sequences and a randomized
// run against a ring-search reference model of the arbiter.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [N-1:0] grant;
    logic [N-1:0] bus_en;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         timeout;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 turnaround, 2 driving
    int m_phase;
    int m_own;
    int m_ptr;
    int m_held;

    bus_arbiter #(.N_SRC(N), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .last     (last),
        .grant    (grant),
        .bus_en   (bus_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] g;
        logic [3:0] e;
        logic [1:0] o;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_own   = 0;
        m_ptr   = N - 1;
        m_held  = 0;
    endfunction

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] l);
        int nx;
        bit rel;
        if (m_phase == 0) begin
            nx = model_pick(r);
            if (nx >= 0) begin
                m_own   = nx;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (r[m_own]) begin
                m_phase = 2;
                m_held  = 1;
            end else begin
                m_ptr   = m_own;
                m_phase = 0;
            end
        end else begin
            rel = !r[m_own] || l[m_own] || (TMO && m_held == MH);
            if (rel) begin
                m_ptr = m_own;
                nx    = model_pick(r);
                if (nx >= 0) begin
                    m_own   = nx;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic logic [31:0] model_vec();
        logic [3:0] g;
        logic [3:0] e;
        logic [1:0] o;
        logic       t;
        g = (m_phase != 0) ? 4'(1 << m_own) : 4'd0;
        e = (m_phase == 2) ? 4'(1 << m_own) : 4'd0;
        o = (m_phase != 0) ? 2'(m_own) : 2'd0;
        t = TMO && m_phase == 2 && m_held == MH;
        return {20'd0, g, e, o, |g, t};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {20'd0, grant, bus_en, owner, bus_busy, timeout};
    endfunction

    task automatic tick(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        req   = '0;
        last  = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("reset_out", dut_vec(), 32'd0);
    endtask

    initial begin
        int seen[$];
        int gap;
        int beats;
        int en0;
        int tcnt;
        bit got2;
        logic [3:0] lnx;
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] msk;

        tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd2};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 2'd2};
        tbl[3]  = '{4'b0110, 4'b0000, 4'b0100, 4'b0100, 2'd2};
        tbl[4]  = '{4'b0110, 4'b0100, 4'b0010, 4'b0000, 2'd1};
        tbl[5]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0};
        tbl[7]  = '{4'b1001, 4'b0000, 4'b1000, 4'b0000, 2'd3};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0};
        tbl[9]  = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 2'd0};
        tbl[10] = '{4'b1001, 4'b1000, 4'b0001, 4'b0001, 2'd0};
        tbl[11] = '{4'b1001, 4'b1110, 4'b0001, 4'b0001, 2'd0};
        tbl[12] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'd3};
        tbl[13] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'd3};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].r, tbl[i].l);
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("tbl%0d_bus_en", i), 32'(bus_en), 32'(tbl[i].e));
            check($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].o));
        end

        // fairness: all request, each owner asserts last on its third beat
        do_reset();
        gap   = 0;
        beats = 0;
        lnx   = '0;
        for (int c = 0; c < 80 && seen.size() < 5; c++) begin
            tick(4'hF, lnx);
            lnx = '0;
            if (bus_en != 0) begin
                if (beats == 0) begin
                    seen.push_back(int'(owner));
                    if (seen.size() > 1) check("fair_gap", 32'(gap), 32'd1);
                end
                beats++;
                gap = 0;
                if (beats == 3) lnx = bus_en;
            end else begin
                gap++;
                beats = 0;
            end
        end
        check("fair_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size(); i++)
            check($sformatf("fair_owner%0d", i), 32'(seen[i]), 32'(i % N));

        // abort during turnaround
        do_reset();
        tick(4'b0010, 4'b0000);
        check("abort_grant1", 32'(grant), 32'(4'b0010));
        check("abort_en1", 32'(bus_en[1]), 32'd0);
        tick(4'b0000, 4'b0000);
        check("abort_idle", 32'({grant, bus_busy}), 32'd0);
        check("abort_en1b", 32'(bus_en[1]), 32'd0);
        tick(4'b1111, 4'b0000);
        check("abort_ptr", 32'(grant), 32'(4'b0100));

        // reset while source 3 drives
        do_reset();
        tick(4'b1000, 4'b0000);
        tick(4'b1000, 4'b0000);
        check("rst_pre_en", 32'(bus_en), 32'(4'b1000));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_en", 32'(bus_en), 32'd0);
        check("rst_async_grant", 32'(grant), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b1111, 4'b0000);
        check("rst_first", 32'(grant), 32'(4'b0001));

        // long hold by source 0 with source 2 pending
        do_reset();
        tick(4'b0001, 4'b0000);
        en0  = 0;
        tcnt = 0;
        got2 = 1'b0;
        for (int c = 0; c < 40 && !got2; c++) begin
            tick(4'b0101, 4'b0000);
            if (bus_en[0]) en0++;
            if (timeout) tcnt++;
            if (grant == 4'b0100) got2 = 1'b1;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        check("hold_en0", 32'(en0), 32'd16);
        check("hold_tmo", 32'(tcnt), 32'd1);
        check("hold_next", 32'(got2), 32'd1);
`else
        check("hold_en0", 32'(en0), 32'd40);
        check("hold_tmo", 32'(tcnt), 32'd0);
        check("hold_next", 32'(got2), 32'd0);
`endif

        // randomized run
        do_reset();
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            msk = '0;
            l   = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) msk[b] = 1'b1;
                if ($urandom_range(3) == 0) l[b] = 1'b1;
            end
            r = r ^ msk;
            tick(r, l);
            check("rand_onehot",
                  32'($onehot0(bus_en) && $onehot0(grant) &&
                      ((bus_en & ~grant) == 0)), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
